// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the regfile write arbiter
package regfile_pkg;

  localparam int RF_REQS_MAX = 16;

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } rf_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - packed write-request bus shared by all requesters
interface regfile_write_arbiter_if #(
  parameter int width = 32,
  parameter int n     = 5,
  parameter int reqs  = 4
);
  localparam int IW = (n == 0) ? 1 : n;

  logic [reqs-1:0]       REQ_VALID;
  logic [reqs*IW-1:0]    REQ_INDEX;
  logic [reqs*width-1:0] REQ_DATA;
  logic [reqs-1:0]       REQ_READY;

  modport master (output REQ_VALID, output REQ_INDEX, output REQ_DATA, input REQ_READY);
  modport slave  (input REQ_VALID, input REQ_INDEX, input REQ_DATA, output REQ_READY);

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int reqs = 4,
  localparam int IDW = clog2(reqs)
) (
  input  logic [reqs-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [reqs-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    // Walk ptr+1 .. ptr+reqs so the last winner gets lowest priority.
    for (int k = 1; k <= reqs; k++) begin
      cand = IDW'((int'(ptr) + k) % reqs);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_id    = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin regfile write port sharing; RF_WRITE_ARB_CLEAR_EN adds clear sequencer
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int width = 32,
  parameter int n     = 5,
  parameter int size  = 32,
  parameter int reqs  = 4,
  localparam int IW   = (n == 0) ? 1 : n,
  localparam int IDW  = clog2(reqs)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  regfile_write_arbiter_if.slave  req,
  input  logic                    CLEAR,
  output logic                    DONE,
  output logic [IDW-1:0]          GRANT_ID,
  output logic                    WRITE_EN_WRITE,
  output logic [IW-1:0]           WRITE_INDEX_WRITE,
  output logic [width-1:0]        WRITE_DATA_WRITE
);

  logic [reqs-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   ptr_q, ptr_d, gid_q, gid_d;
  logic             we_q, we_d;
  logic [IW-1:0]    widx_q, widx_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic             run, clear_take, arb_en, xfer;

  rr_arbiter #(.reqs(reqs)) u_arb (
    .req    (req.REQ_VALID),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

`ifdef RF_WRITE_ARB_CLEAR_EN
  localparam logic [IW-1:0] LAST = IW'(size - 1);
  rf_state_e     state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  assign run        = (state_q == ST_RUN);
  assign clear_take = run & CLEAR;
  assign DONE       = done_q;
`else
  logic unused_clear;
  assign unused_clear = CLEAR;
  assign run          = 1'b1;
  assign clear_take   = 1'b0;
  assign DONE         = 1'b1;
`endif

  // A clear request in RUN suppresses the grant so no write collides with the clear.
  assign arb_en        = RST_N & run & ~clear_take;
  assign req.REQ_READY = arb_en ? gnt : '0;
  assign xfer          = |(req.REQ_VALID & req.REQ_READY);

  always_comb begin
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    we_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    if (xfer) begin
      ptr_d   = gnt_id;
      gid_d   = gnt_id;
      we_d    = 1'b1;
      widx_d  = req.REQ_INDEX[int'(gnt_id)*IW +: IW];
      wdata_d = req.REQ_DATA[int'(gnt_id)*width +: width];
    end
`ifdef RF_WRITE_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (state_q == ST_CLR) begin
      we_d    = 1'b1;
      widx_d  = cnt_q;
      wdata_d = '0;
      if (cnt_q == LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (CLEAR) begin
      state_d = ST_CLR;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q   <= IDW'(reqs - 1);
      gid_q   <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
`ifdef RF_WRITE_ARB_CLEAR_EN
      state_q <= ST_CLR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
`ifdef RF_WRITE_ARB_CLEAR_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`endif
    end
  end

  assign GRANT_ID          = gid_q;
  assign WRITE_EN_WRITE    = we_q;
  assign WRITE_INDEX_WRITE = widx_q;
  assign WRITE_DATA_WRITE  = wdata_q;

endmodule
